// File: rtl/nvme_pkg.sv
// Shared definitions for the NVMe completion tracker: info bit positions, CQ entry fields, FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package nvme_pkg;

    localparam int TRACK_INFO_VALID = 0;
    localparam int TRACK_INFO_ERR   = 1;

    // Completion queue entry DW3 = {status[14:0], phase, cmd_id}
    localparam int CQE_CID_LSB     = 96;
    localparam int CQE_STATUS_LSB  = 113;
    localparam int CQE_STATUS_BITS = 15;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RCLR,
        ST_RNEXT,
        ST_CHECK
    } track_state_t;

endpackage

// File: rtl/nvme_track_ram.sv
// Tracking RAM: one write port plus one read port with optional clear-on-read, read-before-write.
// Latency: read data one cycle after rd_en.
// Backpressure: none; both ports accept every cycle.
module nvme_track_ram #(
    parameter int AW = 12,
    parameter int DW = 2
) (
    input  logic          axi_aclk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // The write port is ordered after the clear so a snooped completion survives a same-cycle retire.
    always_ff @(posedge axi_aclk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            if (rd_clr) begin
                mem[rd_addr] <= '0;
            end
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/nvme_cpl_tracker.sv
// In-order NVMe completion tracker; optional per-action head watchdog under NVME_TRACK_TIMEOUT_EN.
// Latency: update done 4 cycles after accept (1 cycle when the head is not ready); INIT takes one cycle per RAM entry.
// Backpressure: track_update_ready drops while a retire is in flight; completion snooping is never stalled.
module nvme_cpl_tracker
    import nvme_pkg::*;
#(
    parameter int RX_ADDR_BITS    = 10,
    parameter int ACTION_ID_BITS  = 4,
    parameter int REQ_ID_BITS     = 8,
    parameter int TRACK_DEPTH     = 256,
    parameter int TRACK_INFO_BITS = 2,
    parameter int QUEUE_ID_BITS   = 4,
    parameter int CQ_ADDR_LIMIT   = 16,
    parameter int ADMIN_Q0        = 0,
    parameter int ADMIN_Q1        = 8,
    parameter int TIMEOUT_BITS    = 24
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              rx_write_valid,
    input  logic [RX_ADDR_BITS-1:0]           rx_waddr,
    input  logic [127:0]                      rx_wdata,
    output logic                              track_init,
    output logic                              track_overflow,
    input  logic                              track_overflow_clear,
    input  logic                              track_update_valid,
    output logic                              track_update_ready,
    input  logic [ACTION_ID_BITS-1:0]         track_update_id,
    output logic                              track_update_done,
    output logic [TRACK_INFO_BITS-1:0]        track_update_data,
    input  logic                              track_error_clear,
    output logic                              track_error,
    output logic [127:0]                      track_error_data,
    output logic [ACTION_ID_BITS-1:0]         track_error_action,
    output logic [(2**ACTION_ID_BITS)-1:0]    track_status,
    output logic [(2**ACTION_ID_BITS)-1:0]    track_timeout
);

    localparam int NA      = 2**ACTION_ID_BITS;
    localparam int DB      = $clog2(TRACK_DEPTH);
    localparam int AW      = ACTION_ID_BITS + DB;
    localparam int ACT_LSB = CQE_CID_LSB + QUEUE_ID_BITS;
    localparam int REQ_LSB = ACT_LSB + ACTION_ID_BITS;

    if (TRACK_DEPTH != 2**DB || DB > REQ_ID_BITS || TRACK_INFO_BITS < 2 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("nvme_cpl_tracker: unsupported parameter set");
    end

    track_state_t               state_q, state_d;
    logic [AW-1:0]              init_cnt;
    logic [ACTION_ID_BITS-1:0]  upd_id_q;
    logic [DB-1:0]              head [NA];
    logic                       fwd_q, fwd_d;

    logic [QUEUE_ID_BITS-1:0]   cpl_q;
    logic [ACTION_ID_BITS-1:0]  cpl_act;
    logic [DB-1:0]              cpl_idx;
    logic                       cpl_err;
    logic                       cq_wr, cpl_wr, cpl_head_hit, accept, new_head_valid;
    logic [NA-1:0]              head_set;

    logic                       ram_wr_en, ram_rd_en, ram_rd_clr;
    logic [AW-1:0]              ram_wr_addr, ram_rd_addr;
    logic [TRACK_INFO_BITS-1:0] ram_wr_data, ram_rd_data;

    assign cpl_q   = rx_wdata[CQE_CID_LSB +: QUEUE_ID_BITS];
    assign cpl_act = rx_wdata[ACT_LSB +: ACTION_ID_BITS];
    assign cpl_idx = rx_wdata[REQ_LSB +: DB];
    assign cpl_err = |rx_wdata[CQE_STATUS_LSB +: CQE_STATUS_BITS];

    assign cq_wr        = rx_write_valid && (rx_waddr < RX_ADDR_BITS'(CQ_ADDR_LIMIT)) && (state_q != ST_INIT);
    assign cpl_wr       = cq_wr && (cpl_q != QUEUE_ID_BITS'(ADMIN_Q0)) && (cpl_q != QUEUE_ID_BITS'(ADMIN_Q1));
    assign cpl_head_hit = cpl_wr && (cpl_idx == head[cpl_act]);
    assign head_set     = cpl_head_hit ? (NA'(1) << cpl_act) : '0;

    assign track_init         = (state_q != ST_INIT);
    assign track_update_ready = (state_q == ST_IDLE);
    assign accept             = track_update_valid && track_update_ready;
    assign new_head_valid     = ram_rd_data[TRACK_INFO_VALID] | fwd_q;

    always_comb begin
        state_d                       = state_q;
        ram_rd_en                     = 1'b0;
        ram_rd_clr                    = 1'b0;
        ram_rd_addr                   = {upd_id_q, head[upd_id_q]};
        ram_wr_en                     = cpl_wr;
        ram_wr_addr                   = {cpl_act, cpl_idx};
        ram_wr_data                   = '0;
        ram_wr_data[TRACK_INFO_VALID] = 1'b1;
        ram_wr_data[TRACK_INFO_ERR]   = cpl_err;
        // RAM is read-before-write, so a write landing on the RNEXT read address must be carried forward.
        fwd_d                         = cpl_wr && ({cpl_act, cpl_idx} == ram_rd_addr);
        case (state_q)
            ST_INIT: begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = init_cnt;
                ram_wr_data = '0;
                if (init_cnt == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept && track_status[track_update_id]) begin
                    state_d = ST_RCLR;
                end
            end
            ST_RCLR: begin
                ram_rd_en  = 1'b1;
                ram_rd_clr = 1'b1;
                state_d    = ST_RNEXT;
            end
            ST_RNEXT: begin
                ram_rd_en = 1'b1;
                state_d   = ST_CHECK;
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q           <= ST_INIT;
            init_cnt          <= '0;
            upd_id_q          <= '0;
            fwd_q             <= 1'b0;
            track_update_done <= 1'b0;
            track_update_data <= '0;
            for (int a = 0; a < NA; a++) begin
                head[a] <= '0;
            end
        end else begin
            state_q           <= state_d;
            track_update_done <= 1'b0;
            if (state_q == ST_INIT) begin
                init_cnt <= init_cnt + AW'(1);
            end
            if (accept) begin
                upd_id_q <= track_update_id;
                if (!track_status[track_update_id]) begin
                    track_update_done <= 1'b1;
                    track_update_data <= '0;
                end
            end
            if (state_q == ST_RCLR) begin
                head[upd_id_q] <= head[upd_id_q] + DB'(1);
            end
            if (state_q == ST_RNEXT) begin
                track_update_data <= ram_rd_data;
                fwd_q             <= fwd_d;
            end
            if (state_q == ST_CHECK) begin
                track_update_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            track_status   <= '0;
            track_overflow <= 1'b0;
        end else begin
            for (int a = 0; a < NA; a++) begin
                if (state_q == ST_CHECK && upd_id_q == ACTION_ID_BITS'(a)) begin
                    track_status[a] <= new_head_valid | head_set[a];
                end else if (head_set[a]) begin
                    track_status[a] <= 1'b1;
                end else if (accept && track_update_id == ACTION_ID_BITS'(a)) begin
                    track_status[a] <= 1'b0;
                end
            end
            if (track_overflow_clear) begin
                track_overflow <= 1'b0;
            end else if (cpl_head_hit && track_status[cpl_act]) begin
                track_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            track_error        <= 1'b0;
            track_error_data   <= '0;
            track_error_action <= '0;
        end else if (track_error_clear) begin
            track_error        <= 1'b0;
            track_error_data   <= '0;
            track_error_action <= '0;
        end else if (cq_wr && cpl_err && !track_error) begin
            track_error        <= 1'b1;
            track_error_data   <= rx_wdata;
            track_error_action <= cpl_act;
        end
    end

`ifdef NVME_TRACK_TIMEOUT_EN
    logic [DB:0]           issued_cnt  [NA];
    logic [DB:0]           retired_cnt [NA];
    logic [TIMEOUT_BITS-1:0] wdog      [NA];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            track_timeout <= '0;
            for (int a = 0; a < NA; a++) begin
                issued_cnt[a]  <= '0;
                retired_cnt[a] <= '0;
                wdog[a]        <= '0;
            end
        end else begin
            for (int a = 0; a < NA; a++) begin
                if (cpl_wr && cpl_act == ACTION_ID_BITS'(a)) begin
                    issued_cnt[a] <= issued_cnt[a] + (DB+1)'(1);
                end
                if (state_q == ST_RCLR && upd_id_q == ACTION_ID_BITS'(a)) begin
                    retired_cnt[a] <= retired_cnt[a] + (DB+1)'(1);
                    wdog[a]        <= '0;
                end else if (issued_cnt[a] != retired_cnt[a] && wdog[a] != '1) begin
                    wdog[a] <= wdog[a] + TIMEOUT_BITS'(1);
                end
                if (wdog[a] == '1) begin
                    track_timeout[a] <= 1'b1;
                end
            end
        end
    end
`else
    assign track_timeout = '0;
`endif

    nvme_track_ram #(
        .AW (AW),
        .DW (TRACK_INFO_BITS)
    ) u_ram (
        .axi_aclk (axi_aclk),
        .wr_en    (ram_wr_en),
        .wr_addr  (ram_wr_addr),
        .wr_data  (ram_wr_data),
        .rd_en    (ram_rd_en),
        .rd_clr   (ram_rd_clr),
        .rd_addr  (ram_rd_addr),
        .rd_data  (ram_rd_data)
    );

endmodule
